// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//
// Stage-control unit for the five-stage MIPS pipeline. Converts the hazard
// stall request, the ID-stage redirect and the data-memory busy flag into
// per-stage write enables and bubble (flush) controls. A watchdog counts
// consecutive non-advancing cycles and latches a sticky hang error.
//
// Optional feature macro: PIPE_PERF_CNT_EN
//   defined   -> 32-bit stall_cycles / flush_count performance counters
//   undefined -> both counter ports tied to zero, no counter flops
//
// Parameters:
//   MAX_STALL  consecutive stalled cycles tolerated before hang (1..65535)
//   CW         watchdog counter width (derived, do not override)
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   stall        in   hazard request (load-use, branch operand not ready)
//   redirect     in   ID stage resolved a taken branch/jump this cycle
//   mem_busy     in   data memory has not finished the MEM-stage access
//   pc_we        out  PC update enable
//   ifid_we      out  IF/ID write enable
//   ifid_flush   out  IF/ID loads a bubble
//   idex_flush   out  ID/EX loads a bubble
//   exmem_we     out  EX/MEM write enable
//   memwb_we     out  MEM/WB write enable
//   memwb_flush  out  MEM/WB loads a bubble
//   hang         out  sticky watchdog error (registered)
//   stall_cycles out  stalled-cycle counter (PIPE_PERF_CNT_EN only)
//   flush_count  out  redirect-flush counter (PIPE_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned MAX_STALL = 255,
  parameter int unsigned CW        = $clog2(MAX_STALL + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic        mem_busy,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_we,
  output logic        memwb_we,
  output logic        memwb_flush,
  output logic        hang,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    RUN    = 3'd1,
    HAZ    = 3'd2,
    FREEZE = 3'd3,
    HANG   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wd_cnt;

  logic active;
  logic case_mem;
  logic case_stall;
  logic case_redir;
  logic stalled;
  logic wd_limit;

  // The pipeline only reacts to its inputs in the three operating states;
  // INIT and HANG drive fixed control patterns.
  assign active     = (state == RUN) || (state == HAZ) || (state == FREEZE);

  // Priority decode: memory wait beats hazard stall beats redirect.
  assign case_mem   = active &&  mem_busy;
  assign case_stall = active && !mem_busy &&  stall;
  assign case_redir = active && !mem_busy && !stall && redirect;
  assign stalled    = case_mem || case_stall;

  // This stalled cycle is the MAX_STALL-th in a row.
  assign wd_limit   = (wd_cnt == CW'(MAX_STALL - 1));

  // -------------------------------------------------------------------------
  // Combinational stage controls (zero latency from inputs and state)
  // -------------------------------------------------------------------------
  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    memwb_flush = 1'b0;

    unique case (state)
      RUN, HAZ, FREEZE: begin
        if (mem_busy) begin
          // Hold everything up to EX/MEM; retire a bubble into WB so the
          // stuck MEM-stage instruction is not written back twice.
          memwb_we    = 1'b1;
          memwb_flush = 1'b1;
        end else if (stall) begin
          // Hold PC and IF/ID, insert a bubble into EX, let the rest drain.
          // A simultaneous redirect is dropped: the branch re-resolves once
          // its operands are available.
          idex_flush  = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
        end else begin
          pc_we       = 1'b1;
          ifid_we     = 1'b1;
          exmem_we    = 1'b1;
          memwb_we    = 1'b1;
          // Squash the wrong-path instruction fetched behind the branch.
          ifid_flush  = redirect;
        end
      end
      HANG: begin
        // Everything frozen, no bubbles; only reset leaves this state.
      end
      default: begin
        // INIT (and reset): clear the pipeline registers to bubbles.
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        memwb_flush = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state decision
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      INIT: state_nxt = RUN;
      RUN, HAZ, FREEZE: begin
        if (stalled && wd_limit) begin
          state_nxt = HANG;
        end else if (case_mem) begin
          state_nxt = FREEZE;
        end else if (case_stall) begin
          state_nxt = HAZ;
        end else begin
          state_nxt = RUN;
        end
      end
      HANG:    state_nxt = HANG;
      default: state_nxt = INIT;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, watchdog and sticky hang flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= INIT;
      wd_cnt <= '0;
      hang   <= 1'b0;
    end else begin
      state <= state_nxt;
      // HANG is only left through reset, so the flag tracks entry into it.
      hang  <= (state_nxt == HANG);
      if (stalled) begin
        // Saturate rather than wrap.
        if (wd_cnt != CW'(MAX_STALL)) begin
          wd_cnt <= wd_cnt + CW'(1);
        end
      end else begin
        wd_cnt <= '0;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  // -------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32, idle in INIT/HANG)
  // -------------------------------------------------------------------------
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 32'h0;
      flush_cnt <= 32'h0;
    end else begin
      if (stalled) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (case_redir) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cnt;
  assign flush_count  = flush_cnt;
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule
